// File: rtl/rlwe_vmem_pkg.sv
// Shared types and constants for the RLWE vector-memory sequencer: FSM states,
// DMEM command/width/response encodings and the per-coefficient byte size.
package rlwe_vmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    RESP_IDLE   = 2'd0,
    RESP_RDY_OK = 2'd1,
    RESP_RDY_ER = 2'd2
  } dmem_resp_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } dmem_cmd_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE   = 2'd0,
    WIDTH_HALF   = 2'd1,
    WIDTH_WORD   = 2'd2,
    WIDTH_VECTOR = 2'd3
  } dmem_width_e;

  localparam int unsigned COEF_BYTES = 4;
  localparam int unsigned IDX_W      = 7;

  function automatic int unsigned beat_bytes(input int unsigned lane);
    return lane * COEF_BYTES;
  endfunction

endpackage

// File: rtl/rlwe_vmem_addr_gen.sv
// Beat counter, last-beat detect and DMEM address adder for rlwe_vmem_seq.
// The address wraps naturally modulo 2^AWIDTH.
module rlwe_vmem_addr_gen
  import rlwe_vmem_pkg::*;
#(
  parameter int unsigned LANE   = 4,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [AWIDTH-1:0] base,
  input  logic [7:0]        len,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic [AWIDTH-1:0] addr
);

  localparam int unsigned SHIFT = $clog2(beat_bytes(LANE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (step) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign last = ({1'b0, idx} == (len - 8'd1));
  assign addr = base + (AWIDTH'(idx) << SHIFT);

endmodule

// File: rtl/rlwe_vmem_seq.sv
// Polynomial load/store sequencer between the vector register file and DMEM.
// Optional stall counter output enabled by defining RLWE_VMEM_SEQ_PERF_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a request; legality checked here
// ST_ISSUE | DMEM request held until acknowledged
// ST_WAIT  | waiting for the DMEM response of the current beat
module rlwe_vmem_seq
  import rlwe_vmem_pkg::*;
#(
  parameter int unsigned LANE      = 4,
  parameter int unsigned MAX_BEATS = 128,
  parameter int unsigned AWIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exu2seq_req,
  input  logic                 exu2seq_wr,
  input  logic [AWIDTH-1:0]    exu2seq_base,
  input  logic [7:0]           exu2seq_len,
  output logic                 seq2exu_busy,
  output logic                 seq2exu_done,
  output logic                 seq2exu_err,
  output logic [IDX_W-1:0]     seq2vrf_idx,
  input  logic [LANE*32-1:0]   vrf2seq_rdata,
  output logic                 seq2vrf_we,
  output logic [LANE*32-1:0]   seq2vrf_wdata,
  output logic                 seq2dmem_req,
  output logic                 seq2dmem_cmd,
  output logic [1:0]           seq2dmem_width,
  output logic [AWIDTH-1:0]    seq2dmem_addr,
  output logic [LANE*32-1:0]   seq2dmem_wdata,
  input  logic                 dmem2seq_req_ack,
  input  logic [LANE*32-1:0]   dmem2seq_rdata,
  input  logic [1:0]           dmem2seq_resp
`ifdef RLWE_VMEM_SEQ_PERF_EN
  ,
  output logic [31:0]          seq2exu_stall_cnt
`endif
);

  localparam int unsigned ALIGN_W = $clog2(LANE) + 2;

  fsm_e              fsm;
  logic              wr_q;
  logic [AWIDTH-1:0] base_q;
  logic [7:0]        len_q;
  logic              done_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx;
  logic              last;
  logic [AWIDTH-1:0] addr;
  logic              req_legal;
  logic              accept;
  logic              resp_ok;
  logic              resp_er;

  assign req_legal = (exu2seq_base[ALIGN_W-1:0] == '0) &&
                     (exu2seq_len != 8'd0) &&
                     ({24'd0, exu2seq_len} <= 32'(MAX_BEATS));
  assign accept    = (fsm == ST_IDLE) && exu2seq_req && req_legal;
  assign resp_ok   = (fsm == ST_WAIT) && (dmem2seq_resp == RESP_RDY_OK);
  assign resp_er   = (fsm == ST_WAIT) && (dmem2seq_resp == RESP_RDY_ER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= ST_IDLE;
      wr_q   <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (exu2seq_req) begin
            if (req_legal) begin
              wr_q   <= exu2seq_wr;
              base_q <= exu2seq_base;
              len_q  <= exu2seq_len;
              fsm    <= ST_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (dmem2seq_req_ack) fsm <= ST_WAIT;
        end
        ST_WAIT: begin
          if (resp_ok) begin
            if (last) begin
              fsm    <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              fsm <= ST_ISSUE;
            end
          end else if (resp_er) begin
            fsm   <= ST_IDLE;
            err_q <= 1'b1;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  rlwe_vmem_addr_gen #(
    .LANE   (LANE),
    .AWIDTH (AWIDTH)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .step  (resp_ok && !last),
    .base  (base_q),
    .len   (len_q),
    .idx   (idx),
    .last  (last),
    .addr  (addr)
  );

  assign seq2exu_busy   = (fsm != ST_IDLE);
  assign seq2exu_done   = done_q;
  assign seq2exu_err    = err_q;
  assign seq2vrf_idx    = idx;
  assign seq2dmem_req   = (fsm == ST_ISSUE);
  assign seq2dmem_cmd   = (seq2dmem_req && wr_q) ? CMD_WR : CMD_RD;
  // Width only qualifies an active request so the bus reads all-zero when quiet.
  assign seq2dmem_width = seq2dmem_req ? WIDTH_VECTOR : WIDTH_BYTE;
  assign seq2dmem_addr  = addr;
  assign seq2dmem_wdata = (seq2dmem_req && wr_q) ? vrf2seq_rdata : '0;
  assign seq2vrf_we     = resp_ok && !wr_q;
  assign seq2vrf_wdata  = seq2vrf_we ? dmem2seq_rdata : '0;

`ifdef RLWE_VMEM_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq2exu_stall_cnt <= '0;
    end else if ((fsm == ST_ISSUE) && !dmem2seq_req_ack && (seq2exu_stall_cnt != '1)) begin
      seq2exu_stall_cnt <= seq2exu_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
